// File: rtl/ex_alu_datapath_if.sv
// Execute-stage bundle: decoded operands from ID, forwarding controls and
// bypass values from the hazard unit, and the ALU results handed to MEM.
interface ex_alu_datapath_if;
  logic        stall;
  logic [31:0] d_bus_a;
  logic [31:0] d_bus_b;
  logic [31:0] d_imm32;
  logic        d_alu_src;
  logic [3:0]  d_alu_ctrl;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic [31:0] prior_alu_result;
  logic [31:0] alu_writeback;
  logic [31:0] alu_out;
  logic        zero;
  logic        overflow;
  logic [31:0] bus_b;

  modport master (
    output stall, d_bus_a, d_bus_b, d_imm32, d_alu_src, d_alu_ctrl,
           fwd_sel_a, fwd_sel_b, prior_alu_result, alu_writeback,
    input  alu_out, zero, overflow, bus_b
  );

  modport slave (
    input  stall, d_bus_a, d_bus_b, d_imm32, d_alu_src, d_alu_ctrl,
           fwd_sel_a, fwd_sel_b, prior_alu_result, alu_writeback,
    output alu_out, zero, overflow, bus_b
  );
endinterface

// File: rtl/ex_alu_datapath.sv
// Execute stage: ID/EX pipeline register, operand forwarding muxes and a
// 16-operation ALU. Everything after the stage register is combinational.
package ex_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOR  = 4'h5,
    OP_SLT  = 4'h6,
    OP_SLTU = 4'h7,
    OP_SLL  = 4'h8,
    OP_SRL  = 4'h9,
    OP_SRA  = 4'hA,
    OP_LUI  = 4'hB,
    OP_SEQ  = 4'hC,
    OP_SNE  = 4'hD,
    OP_PASA = 4'hE,
    OP_PASB = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm32;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
  } stage_t;
endpackage

module ex_mux2 #(
  parameter int n = 32
) (
  input  logic         sel,
  input  logic [n-1:0] in0,
  input  logic [n-1:0] in1,
  output logic [n-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module ex_mux4 #(
  parameter int n = 32
) (
  input  logic [1:0]   sel,
  input  logic [n-1:0] in0,
  input  logic [n-1:0] in1,
  input  logic [n-1:0] in2,
  input  logic [n-1:0] in3,
  output logic [n-1:0] out
);
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps this block from ever inferring a latch.
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end
endmodule

module ex_alu
  import ex_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        overflow
);
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = a[4:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (alu_op_e'(ctrl))
      OP_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'b0, a < b};
      // Shifts move B by the low five bits of A, MIPS-style.
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = $unsigned($signed(b) >>> shamt);
      OP_LUI:  result = {b[15:0], 16'h0000};
      OP_SEQ:  result = {31'b0, a == b};
      OP_SNE:  result = {31'b0, a != b};
      OP_PASA: result = a;
      OP_PASB: result = b;
    endcase
  end
endmodule

module ex_alu_datapath
  import ex_alu_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  ex_alu_datapath_if.slave ex
);
  stage_t      stage;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] opnd_b;
  logic [31:0] result;
  logic        ovf;

  // A stall squashes the instruction into a bubble that computes 0 + 0.
  always_ff @(posedge clk) begin
    if (!reset_n || ex.stall) begin
      // NOTE: registered state is always updated with non-blocking assignments.
      stage <= '0;
    end else begin
      stage <= '{bus_a:    ex.d_bus_a,
                 bus_b:    ex.d_bus_b,
                 imm32:    ex.d_imm32,
                 alu_src:  ex.d_alu_src,
                 alu_ctrl: ex.d_alu_ctrl};
    end
  end

  ex_mux4 #(.n(32)) u_fwd_a (
    .sel (ex.fwd_sel_a),
    .in0 (stage.bus_a),
    .in1 (ex.prior_alu_result),
    .in2 (ex.alu_writeback),
    .in3 (32'h0),
    .out (fwd_a)
  );

  ex_mux4 #(.n(32)) u_fwd_b (
    .sel (ex.fwd_sel_b),
    .in0 (stage.bus_b),
    .in1 (ex.prior_alu_result),
    .in2 (ex.alu_writeback),
    .in3 (32'h0),
    .out (fwd_b)
  );

  ex_mux2 #(.n(32)) u_src_b (
    .sel (stage.alu_src),
    .in0 (fwd_b),
    .in1 (stage.imm32),
    .out (opnd_b)
  );

  ex_alu u_alu (
    .a        (fwd_a),
    .b        (opnd_b),
    .ctrl     (stage.alu_ctrl),
    .result   (result),
    .overflow (ovf)
  );

  assign ex.alu_out  = result;
  assign ex.zero     = (result == 32'h0);
  assign ex.overflow = ovf;
  // Store data bypasses forwarding; MEM applies its own forwarding to it.
  assign ex.bus_b    = stage.bus_b;
endmodule

// File: tb/tb_ex_alu_datapath.sv
// Directed bench for ex_alu_datapath: reset, ALU opcodes, forwarding, stall,
// back-to-back issue and synchronous reset timing.
module tb_ex_alu_datapath;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  ex_alu_datapath_if ex ();

  ex_alu_datapath dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ex      (ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src);
    ex.d_alu_ctrl = op;
    ex.d_bus_a    = a;
    ex.d_bus_b    = b;
    ex.d_imm32    = imm;
    ex.d_alu_src  = src;
  endtask

  task automatic expect_out(input string name, input logic [31:0] exp_out,
                            input logic exp_zero, input logic exp_ovf);
    checks++;
    if (ex.alu_out !== exp_out) begin
      failures++;
      $display("FAIL %s alu_out got=%h exp=%h", name, ex.alu_out, exp_out);
    end
    checks++;
    if (ex.zero !== exp_zero) begin
      failures++;
      $display("FAIL %s zero got=%b exp=%b", name, ex.zero, exp_zero);
    end
    checks++;
    if (ex.overflow !== exp_ovf) begin
      failures++;
      $display("FAIL %s overflow got=%b exp=%b", name, ex.overflow, exp_ovf);
    end
  endtask

  task automatic expect_bus_b(input string name, input logic [31:0] exp);
    checks++;
    if (ex.bus_b !== exp) begin
      failures++;
      $display("FAIL %s bus_b got=%h exp=%h", name, ex.bus_b, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_ovf);
    drive(op, a, b, 32'h0, 1'b0);
    step();
    expect_out(name, exp, exp == 32'h0, exp_ovf);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ex.stall = 1'b1;
    drive(4'h4, 32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_5555, 1'b1);
    step();
    ex.stall = 1'b0;
    expect_out("reset", 32'h0, 1'b1, 1'b0);
    expect_bus_b("reset", 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    drive(4'h0, 32'd5, 32'd7, 32'h0, 1'b0);
    step();
    expect_out("add_5_7", 32'd12, 1'b0, 1'b0);
    expect_bus_b("add_5_7", 32'd7);
  endtask

  task automatic test_alu_ops();
    run_op("add_ovf",  4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_op("add_neg",  4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_zero", 4'h1, 32'd3,         32'd3,         32'h0,         1'b0);
    run_op("sub_ovf",  4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    run_op("sub_neg",  4'h1, 32'd1,         32'hFFFF_FFFF, 32'd2,         1'b0);
    run_op("and",      4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    run_op("or",       4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
    run_op("xor",      4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    run_op("nor",      4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0);
    run_op("slt_t",    4'h6, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    run_op("slt_f",    4'h6, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);
    run_op("sltu_f",   4'h7, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    run_op("sltu_t",   4'h7, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0);
    run_op("sll_hiA",  4'h8, 32'h0000_0024, 32'd1,         32'h10,        1'b0);
    run_op("srl",      4'h9, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0);
    run_op("sra",      4'hA, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0);
    run_op("sra_31",   4'hA, 32'h0000_003F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("lui",      4'hB, 32'hFFFF_FFFF, 32'hABCD_1234, 32'h1234_0000, 1'b0);
    run_op("seq_t",    4'hC, 32'd5,         32'd5,         32'd1,         1'b0);
    run_op("seq_f",    4'hC, 32'd5,         32'd6,         32'd0,         1'b0);
    run_op("sne_t",    4'hD, 32'd5,         32'd6,         32'd1,         1'b0);
    run_op("pass_a",   4'hE, 32'hDEAD_BEEF, 32'd1,         32'hDEAD_BEEF, 1'b0);
    run_op("pass_b",   4'hF, 32'd1,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    run_op("and_noov", 4'h2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
  endtask

  task automatic test_forwarding();
    ex.prior_alu_result = 32'd100;
    ex.alu_writeback    = 32'd200;
    drive(4'h0, 32'd1, 32'd9, 32'd4, 1'b1);
    step();
    expect_out("fwd_sel0", 32'd5, 1'b0, 1'b0);
    ex.fwd_sel_a = 2'd1;
    #1;
    expect_out("fwd_sel1", 32'd104, 1'b0, 1'b0);
    ex.fwd_sel_a = 2'd2;
    #1;
    expect_out("fwd_sel2", 32'd204, 1'b0, 1'b0);
    ex.fwd_sel_a = 2'd3;
    #1;
    expect_out("fwd_sel3", 32'd4, 1'b0, 1'b0);
    // With src=0, B comes from fwd_sel_b; bus_b stays the registered value.
    ex.fwd_sel_a = 2'd0;
    drive(4'h0, 32'd1, 32'd9, 32'd4, 1'b0);
    step();
    ex.fwd_sel_b = 2'd2;
    #1;
    expect_out("fwdb_sel2", 32'd201, 1'b0, 1'b0);
    expect_bus_b("fwdb_sel2", 32'd9);
    ex.fwd_sel_b = 2'd1;
    #1;
    expect_out("fwdb_sel1", 32'd101, 1'b0, 1'b0);
    ex.fwd_sel_b = 2'd3;
    #1;
    expect_out("fwdb_sel3", 32'd1, 1'b0, 1'b0);
    ex.fwd_sel_b = 2'd0;
  endtask

  task automatic test_stall();
    drive(4'h0, 32'd5, 32'd7, 32'h0, 1'b0);
    step();
    expect_out("pre_stall", 32'd12, 1'b0, 1'b0);
    ex.stall = 1'b1;
    step();
    ex.stall = 1'b0;
    expect_out("stall", 32'h0, 1'b1, 1'b0);
    expect_bus_b("stall", 32'h0);
  endtask

  task automatic test_back_to_back();
    drive(4'h0, 32'd10, 32'd3, 32'h0, 1'b0);
    step();
    drive(4'h1, 32'd10, 32'd3, 32'h0, 1'b0);
    #1;
    expect_out("b2b_hold", 32'd13, 1'b0, 1'b0);
    step();
    expect_out("b2b_sub", 32'd7, 1'b0, 1'b0);
    drive(4'h2, 32'd10, 32'd3, 32'h0, 1'b0);
    step();
    expect_out("b2b_and", 32'd2, 1'b0, 1'b0);
  endtask

  task automatic test_sync_reset();
    drive(4'h0, 32'd5, 32'd7, 32'h0, 1'b0);
    step();
    #3;
    reset_n = 1'b0;
    drive(4'h3, 32'hAAAA_0000, 32'h0000_5555, 32'h1111_1111, 1'b1);
    #1;
    expect_out("rst_mid", 32'd12, 1'b0, 1'b0);
    expect_bus_b("rst_mid", 32'd7);
    step();
    expect_out("rst_edge", 32'h0, 1'b1, 1'b0);
    expect_bus_b("rst_edge", 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    ex.stall = 1'b0;
    ex.fwd_sel_a = 2'd0;
    ex.fwd_sel_b = 2'd0;
    ex.prior_alu_result = 32'h0;
    ex.alu_writeback    = 32'h0;
    drive(4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    test_reset();
    test_add();
    test_alu_ops();
    test_forwarding();
    test_stall();
    test_back_to_back();
    test_sync_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_alu_datapath.md
EX_ALU_DATAPATH -- requirements
Module: ex_alu_datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port stall, input, 1 bit: when 1, the stage register loads a bubble.
REQ-004 SHALL have ports d_bus_a, d_bus_b and d_imm32, inputs, 32 bits each: register-file operands and the extended immediate.
REQ-005 SHALL have port d_alu_src, input, 1 bit (0 = forwarded B, 1 = immediate), and port d_alu_ctrl, input, 4 bits: ALU opcode.
REQ-006 SHALL have ports fwd_sel_a and fwd_sel_b, inputs, 2 bits each: forwarding selects, combinational, not registered.
REQ-007 SHALL have ports prior_alu_result and alu_writeback, inputs, 32 bits each: MEM-stage and WB-stage forwarding values.
REQ-008 SHALL have port alu_out, output, 32 bits: combinational ALU result.
REQ-009 SHALL have port zero, output, 1 bit: 1 when alu_out == 0.
REQ-010 SHALL have port overflow, output, 1 bit: signed overflow, valid for ADD and SUB only, 0 for all other opcodes.
REQ-011 SHALL have port bus_b, output, 32 bits: registered, unforwarded B operand for store data.

Function
REQ-012 Stage register fields: bus_a, bus_b, imm32, alu_src, alu_ctrl.
REQ-013 Stage register update on rising edge, priority order:
- reset_n = 0: all fields cleared to 0.
- else stall = 1: all fields cleared to 0 (bubble).
- else: each field loads its d_* input.
REQ-014 Forward mux A (4:1, 32 bit) on fwd_sel_a: 0 = registered bus_a, 1 = prior_alu_result, 2 = alu_writeback, 3 = 32'h0.
REQ-015 Forward mux B: same mapping, on fwd_sel_b, with registered bus_b as source 0.
REQ-016 Operand B mux (2:1, 32 bit): forwarded B when registered alu_src = 0, registered imm32 when 1.
REQ-017 ALU opcodes, with A = forwarded A and B = operand-B mux output:
- 0x0 ADD, 0x1 SUB (A-B), 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 NOR.
- 0x6 SLT (signed), 0x7 SLTU.
- 0x8 SLL: B << A[4:0]; 0x9 SRL; 0xA SRA (arithmetic).
- 0xB LUI: B << 16.
- 0xC SEQ, 0xD SNE.
- 0xE pass A; 0xF pass B.
REQ-018 Compare and set ops (SLT, SLTU, SEQ, SNE) SHALL return 32'h1 or 32'h0.
REQ-019 Add and subtract SHALL wrap modulo 2^32.
REQ-020 overflow SHALL be set for ADD when A and B have the same sign and the result sign differs, and for SUB when A and B signs differ and the result sign differs from A.
REQ-021 Muxes and ALU SHALL be purely combinational; latency from d_* to alu_out is exactly one clock edge; forwarding inputs take effect in the same cycle.
REQ-022 Shift amounts SHALL use only A[4:0]; A[31:5] is ignored.
REQ-023 The mux and ALU functions SHALL be built as reusable submodules (2:1 and 4:1 muxes parameterized by width n, default 32; the ALU) instantiated in ex_alu_datapath.

Reset
REQ-024 After reset, all register fields SHALL be 0; with fwd_sel_a = fwd_sel_b = 0 the outputs SHALL be alu_out = 0, zero = 1, overflow = 0, bus_b = 0.
REQ-025 Reset SHALL override stall and data inputs in the same edge; behaviour before the first reset is don't-care.

Verification
REQ-026 Basic ADD: d_bus_a=5, d_bus_b=7, ctrl=0x0, src=0, sel=0/0, one edge -> alu_out=12, zero=0, bus_b=7.
REQ-027 Overflow and SUB:
- ADD 32'h7FFFFFFF + 1 -> alu_out=32'h80000000, overflow=1.
- SUB 3-3 -> alu_out=0, zero=1.
REQ-028 Forwarding: registered A=1; prior_alu_result=100, alu_writeback=200, d_imm32=4, src=1, ctrl ADD:
- sel_a=1 -> 104.
- sel_a=2 -> 204.
- sel_a=3 -> 4.
REQ-029 Stall: load ADD 5+7, then one edge with stall=1 -> alu_out=0, bus_b=0, zero=1.
REQ-030 Shift and compare:
- SRA with A=4, B=32'h80000000 -> 32'hF8000000.
- SLT -1 < 1 -> 1.
- SLTU 32'hFFFFFFFF < 1 -> 0.
REQ-031 Synchronous reset: reset_n=0 asserted mid-cycle with nonzero data -> outputs unchanged until the next rising edge, then REQ-024 values.
